// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM behind a valid/ready request port.
// It services one RV32I byte, halfword or word load/store at a time and returns
// the response LATENCY+1 cycles after the request is accepted.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, a misaligned
// halfword or word access faults. When it is undefined, the low address bits
// are forced to alignment.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e state_q, state_d;

  logic [3:0]    cnt_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    f3_q;
  logic          is_store_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic accept;
  logic commit;
  logic rsp_hs;

  // Upper address bits are ignored so that addresses wrap modulo the depth.
  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  assign accept = (state_q == StIdle) && req_valid && (mem_read || mem_write);
  assign commit = (state_q == StBusy) && (cnt_q == 4'd0);
  assign rsp_hs = (state_q == StResp) && rsp_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StBusy;
      StBusy:  if (commit) state_d = StResp;
      StResp:  if (rsp_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
  end

  assign rdata = rdata_q;
  assign err   = err_q;

  // Access decode for the latched request
  logic [AW-1:0] idx;
  logic [1:0]    lo;
  logic          misalign;
  logic          illegal;
  logic          fault;

  assign idx = addr_q[AW+1:2];

  always_comb begin
    lo       = addr_q[1:0];
    misalign = 1'b0;
    case (f3_q[1:0])
      2'b01: begin
        misalign = addr_q[0];
        lo[0]    = 1'b0;
      end
      2'b10: begin
        misalign = |addr_q[1:0];
        lo       = 2'b00;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (is_store_q) begin
      illegal = f3_q[2] || (f3_q[1:0] == 2'b11);
    end else begin
      illegal = (f3_q[1:0] == 2'b11) || (f3_q == 3'b110);
    end
`ifdef MISALIGN_TRAP_EN
    fault = illegal || misalign;
`else
    fault = illegal;
`endif
  end

  // Load lane extraction and extension
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_data;

  assign rd_word = mem[idx];
  assign rd_byte = rd_word[{lo, 3'b000} +: 8];
  assign rd_half = lo[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = 32'h0;
    case (f3_q)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'h0, rd_byte};
      3'b101:  ld_data = {16'h0, rd_half};
      default: ld_data = 32'h0;
    endcase
    if (fault || is_store_q) ld_data = 32'h0;
  end

  // Store byte enables, with the data replicated across all lanes
  logic [3:0]  st_be;
  logic [31:0] st_data;

  always_comb begin
    st_be   = 4'b0000;
    st_data = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        st_be   = 4'b0001 << lo;
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_be   = lo[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      2'b10: st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
    if (fault || !is_store_q) st_be = 4'b0000;
  end

  // Request latch, latency counter and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      f3_q       <= 3'b000;
      is_store_q <= 1'b0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q      <= 4'(LATENCY);
        addr_q     <= addr[AW+1:0];
        wdata_q    <= wdata;
        f3_q       <= funct3;
        is_store_q <= mem_write;
      end else if ((state_q == StBusy) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (commit) begin
        rdata_q <= ld_data;
        err_q   <= fault;
      end
    end
  end

  // RAM write at commit; contents are not reset, and an access abandoned by
  // reset never reaches commit.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder with LATENCY=2 and DEPTH_WORDS=1024.
module tb_dmem_responder;

  localparam int unsigned Depth = 1024;
  localparam int unsigned Lat   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        rsp_valid, rsp_ready, err;

  int n_pass = 0;
  int n_chk  = 0;

  dmem_responder #(
    .DEPTH_WORDS(Depth),
    .LATENCY    (Lat)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rdata    (rdata),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One full transaction: request, latency measurement, optional stall, handshake.
  task automatic xact(input string tag, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input int hold,
                      input logic [31:0] exp_rd, input logic exp_err);
    int          cyc;
    logic [31:0] rd0;
    logic        er0;
    @(negedge clk);
    chk({tag, " idle_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    mem_write = wr;
    mem_read  = !wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    chk({tag, " busy_ready"}, {31'b0, req_ready}, 32'd0);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, " latency"}, cyc, Lat + 1);
    chk({tag, " rdata"}, rdata, exp_rd);
    chk({tag, " err"}, {31'b0, err}, {31'b0, exp_err});
    rd0 = rdata;
    er0 = err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, " hold_valid"}, {31'b0, rsp_valid}, 32'd1);
      chk({tag, " hold_rdata"}, rdata, rd0);
      chk({tag, " hold_err"}, {31'b0, err}, {31'b0, er0});
      chk({tag, " hold_ready"}, {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, " hs_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, " hs_ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'b000;
    addr      = 32'h0;
    wdata     = 32'h0;
    rsp_ready = 1'b0;
    #1;
    chk("rst req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst rdata", rdata, 32'h0);
    chk("rst err", {31'b0, err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Word store/load
    xact("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0);
    xact("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0);

    // Byte lane 1 store, signed/unsigned byte loads
    xact("sb11", 1'b1, 3'b000, 32'h11, 32'h00000080, 0, 32'h0, 1'b0);
    xact("lb11", 1'b0, 3'b000, 32'h11, 32'h0, 0, 32'hFFFFFF80, 1'b0);
    xact("lbu11", 1'b0, 3'b100, 32'h11, 32'h0, 0, 32'h00000080, 1'b0);
    xact("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 0, 32'hDEAD80EF, 1'b0);

    // Upper halfword store, halfword loads, stalled word load
    xact("sw20", 1'b1, 3'b010, 32'h20, 32'h00000000, 0, 32'h0, 1'b0);
    xact("sh22", 1'b1, 3'b001, 32'h22, 32'h00008001, 0, 32'h0, 1'b0);
    xact("lh22", 1'b0, 3'b001, 32'h22, 32'h0, 0, 32'hFFFF8001, 1'b0);
    xact("lhu22", 1'b0, 3'b101, 32'h22, 32'h0, 0, 32'h00008001, 1'b0);
    xact("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 5, 32'h80010000, 1'b0);

    // Store abandoned by a reset while it is in BUSY
    xact("sw30", 1'b1, 3'b010, 32'h30, 32'h11112222, 0, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    mem_write = 1'b1;
    funct3    = 3'b010;
    addr      = 32'h30;
    wdata     = 32'h33334444;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_write = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort req_ready", {31'b0, req_ready}, 32'd1);
    chk("abort rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xact("lw30", 1'b0, 3'b010, 32'h30, 32'h0, 0, 32'h11112222, 1'b0);

    // Address wrap modulo depth
    xact("swwrap", 1'b1, 3'b010, Depth * 4 + 4, 32'hCAFEF00D, 0, 32'h0, 1'b0);
    xact("lw04", 1'b0, 3'b010, 32'h4, 32'h0, 0, 32'hCAFEF00D, 1'b0);

    // Illegal funct3 on load and store; the store must not write
    xact("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 0, 32'h0, 1'b1);
    xact("st011", 1'b1, 3'b011, 32'h10, 32'h12345678, 0, 32'h0, 1'b1);
    xact("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 0, 32'hDEAD80EF, 1'b0);

    // Misaligned word load
`ifdef MISALIGN_TRAP_EN
    xact("lw13", 1'b0, 3'b010, 32'h13, 32'h0, 0, 32'h0, 1'b1);
`else
    xact("lw13", 1'b0, 3'b010, 32'h13, 32'h0, 0, 32'hDEAD80EF, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
